// File: rtl/oflow_calc_iou_gen.sv
// IoU / IoU-distance engine for the oflow tracker: box pair in, FRAC_W-bit fraction out.
// Coordinates -> areas -> bit-serial restoring divide, with degenerate pairs bypassing the divider.
module oflow_calc_iou_gen #(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned FRAC_W  = 22
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [4*COORD_W-1:0]   bbox_k,
  input  logic [4*COORD_W-1:0]   bbox_hist,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAC_W-1:0]      iou,
  output logic                   busy
);

  localparam int unsigned BOX_W  = 4 * COORD_W;
  localparam int unsigned AREA_W = 2 * COORD_W;
  localparam int unsigned UNI_W  = AREA_W + 1;
  localparam int unsigned REM_W  = AREA_W + 2;
  localparam int unsigned CNT_W  = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;
  localparam logic [FRAC_W-1:0] Q_ONE = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COORD,
    S_AREA,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_nx;

  logic [BOX_W-1:0]   box_k_q, box_h_q;
  logic               mode_q;
  logic [COORD_W-1:0] ix0_q, iy0_q, ix1_q, iy1_q;
  logic [COORD_W-1:0] wk_q, hk_q, wh_q, hh_q;
  logic [UNI_W-1:0]   uni_q;
  logic [REM_W-1:0]   rem_q;
  logic [FRAC_W-1:0]  q_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [COORD_W-1:0] kx0, ky0, kx1, ky1, hx0, hy0, hx1, hy1;
  logic [AREA_W-1:0]  area_k, area_h, inter;
  logic [UNI_W-1:0]   uni;
  logic               short_cut, div_last, rem_ge;
  logic [FRAC_W-1:0]  short_q, q_nx;
  logic [REM_W-1:0]   rem_sh, rem_nx;
  logic               accept;

  function automatic logic [COORD_W-1:0] span(input logic [COORD_W-1:0] lo,
                                               input logic [COORD_W-1:0] hi);
    return (hi > lo) ? COORD_W'(hi - lo) : '0;
  endfunction

  function automatic logic [FRAC_W-1:0] pick(input logic md, input logic [FRAC_W-1:0] q);
    return md ? q : FRAC_W'(Q_ONE - q);
  endfunction

  assign in_ready = (state_q == S_IDLE) && !reset_N;
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;

  // Field unpacking: {X_TL, Y_TL, X_BR, Y_BR}, X_TL in the MSBs
  assign kx0 = box_k_q[BOX_W-1 -: COORD_W];
  assign ky0 = box_k_q[3*COORD_W-1 -: COORD_W];
  assign kx1 = box_k_q[2*COORD_W-1 -: COORD_W];
  assign ky1 = box_k_q[COORD_W-1:0];
  assign hx0 = box_h_q[BOX_W-1 -: COORD_W];
  assign hy0 = box_h_q[3*COORD_W-1 -: COORD_W];
  assign hx1 = box_h_q[2*COORD_W-1 -: COORD_W];
  assign hy1 = box_h_q[COORD_W-1:0];

  // Area stage; I <= min(Ak, Ah) so U never underflows
  assign area_k    = AREA_W'(wk_q) * AREA_W'(hk_q);
  assign area_h    = AREA_W'(wh_q) * AREA_W'(hh_q);
  assign inter     = AREA_W'(span(ix0_q, ix1_q)) * AREA_W'(span(iy0_q, iy1_q));
  assign uni       = UNI_W'(area_k) + UNI_W'(area_h) - UNI_W'(inter);
  assign short_cut = (inter == '0) || (UNI_W'(inter) == uni);
  assign short_q   = (inter == '0) ? '0 : Q_ONE;

  // One restoring-divide step; the remainder stays below U so the shift cannot overflow
  assign rem_sh   = rem_q << 1;
  assign rem_ge   = (rem_sh >= REM_W'(uni_q));
  assign rem_nx   = rem_ge ? REM_W'(rem_sh - REM_W'(uni_q)) : rem_sh;
  assign q_nx     = FRAC_W'(q_q << 1) | FRAC_W'(rem_ge);
  assign div_last = (cnt_q == CNT_W'(FRAC_W - 1));

  always_ff @(posedge clk) begin
    if (reset_N) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_nx = S_COORD;
      S_COORD: state_nx = S_AREA;
      S_AREA:  state_nx = short_cut ? S_DONE : S_DIV;
      S_DIV:   if (div_last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      box_k_q   <= '0;
      box_h_q   <= '0;
      mode_q    <= 1'b0;
      ix0_q     <= '0;
      iy0_q     <= '0;
      ix1_q     <= '0;
      iy1_q     <= '0;
      wk_q      <= '0;
      hk_q      <= '0;
      wh_q      <= '0;
      hh_q      <= '0;
      uni_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      iou       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nx == S_DONE);
      if (accept) begin
        box_k_q <= bbox_k;
        box_h_q <= bbox_hist;
        mode_q  <= mode;
      end
      if (state_q == S_COORD) begin
        ix0_q <= (kx0 > hx0) ? kx0 : hx0;
        iy0_q <= (ky0 > hy0) ? ky0 : hy0;
        ix1_q <= (kx1 < hx1) ? kx1 : hx1;
        iy1_q <= (ky1 < hy1) ? ky1 : hy1;
        wk_q  <= span(kx0, kx1);
        hk_q  <= span(ky0, ky1);
        wh_q  <= span(hx0, hx1);
        hh_q  <= span(hy0, hy1);
      end
      if (state_q == S_AREA) begin
        uni_q <= uni;
        rem_q <= REM_W'(inter);
        q_q   <= short_cut ? short_q : '0;
        cnt_q <= '0;
        if (short_cut) iou <= pick(mode_q, short_q);
      end
      if (state_q == S_DIV) begin
        rem_q <= rem_nx;
        q_q   <= q_nx;
        cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
        if (div_last) iou <= pick(mode_q, q_nx);
      end
    end
  end

endmodule

// File: tb/tb_oflow_calc_iou_gen.sv
// Directed and randomized checks of oflow_calc_iou_gen at default and 8/8 parameters.
module tb_oflow_calc_iou_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters; instance 1: COORD_W=8, FRAC_W=8
  logic        rst0, iv0, ir0, md0, ov0, or0, busy0;
  logic [43:0] bk0, bh0;
  logic [21:0] iou0;
  logic        rst1, iv1, ir1, md1, ov1, or1, busy1;
  logic [31:0] bk1, bh1;
  logic [7:0]  iou1;

  int errors = 0;
  int checks = 0;

  oflow_calc_iou_gen dut0 (
    .clk(clk), .reset_N(rst0), .in_valid(iv0), .in_ready(ir0), .mode(md0),
    .bbox_k(bk0), .bbox_hist(bh0), .out_valid(ov0), .out_ready(or0),
    .iou(iou0), .busy(busy0)
  );

  oflow_calc_iou_gen #(.COORD_W(8), .FRAC_W(8)) dut1 (
    .clk(clk), .reset_N(rst1), .in_valid(iv1), .in_ready(ir1), .mode(md1),
    .bbox_k(bk1), .bbox_hist(bh1), .out_valid(ov1), .out_ready(or1),
    .iou(iou1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] box11(input int a, input int b, input int c, input int d);
    return {11'(a), 11'(b), 11'(c), 11'(d)};
  endfunction

  function automatic logic [43:0] box8(input int a, input int b, input int c, input int d);
    return {12'd0, 8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  // Reference: IoU from plain integer geometry and exact integer division
  function automatic longint unsigned fld(input logic [43:0] b, input int cw, input int idx);
    longint unsigned v = longint'(b);
    return (v >> (cw * (3 - idx))) & ((64'd1 << cw) - 1);
  endfunction

  function automatic longint unsigned rect_area(input longint unsigned x0, input longint unsigned y0,
                                                input longint unsigned x1, input longint unsigned y1);
    longint unsigned w = (x1 > x0) ? x1 - x0 : 0;
    longint unsigned h = (y1 > y0) ? y1 - y0 : 0;
    return w * h;
  endfunction

  task automatic ref_model(input logic [43:0] k, input logic [43:0] h, input int cw, input int frac,
                           input bit md, output longint unsigned res, output int lat);
    longint unsigned kx0, ky0, kx1, ky1, hx0, hy0, hx1, hy1, ak, ah, i, u, q, one;
    kx0 = fld(k, cw, 0); ky0 = fld(k, cw, 1); kx1 = fld(k, cw, 2); ky1 = fld(k, cw, 3);
    hx0 = fld(h, cw, 0); hy0 = fld(h, cw, 1); hx1 = fld(h, cw, 2); hy1 = fld(h, cw, 3);
    ak = rect_area(kx0, ky0, kx1, ky1);
    ah = rect_area(hx0, hy0, hx1, hy1);
    i = rect_area((kx0 > hx0) ? kx0 : hx0, (ky0 > hy0) ? ky0 : hy0,
                  (kx1 < hx1) ? kx1 : hx1, (ky1 < hy1) ? ky1 : hy1);
    u = ak + ah - i;
    one = (64'd1 << frac) - 1;
    lat = 3;
    if (u == 0 || i == 0) q = 0;
    else if (i == u) q = one;
    else begin
      q = (i << frac) / u;
      if (q > one) q = one;
      lat = frac + 3;
    end
    res = md ? q : one - q;
  endtask

  // Present a request and return #1 after the edge that accepts it
  task automatic start_job(input bit sel, input logic [43:0] k, input logic [43:0] h, input bit md);
    int g = 0;
    if (sel) begin bk1 = k[31:0]; bh1 = h[31:0]; md1 = md; iv1 = 1'b1; end
    else     begin bk0 = k;       bh0 = h;       md0 = md; iv0 = 1'b1; end
    while (!(sel ? ir1 : ir0) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check("accept_ready", 64'(sel ? ir1 : ir0), 64'd1);
    @(posedge clk); #1;
    if (sel) iv1 = 1'b0; else iv0 = 1'b0;
  endtask

  // Latency counts the accept cycle as cycle 1, so out_valid seen n edges later gives n+1
  task automatic wait_done(input bit sel, output int lat, output logic [21:0] res);
    int n = 0;
    res = '0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (sel ? ov1 : ov0) break;
    end
    lat = n + 1;
    res = sel ? 22'(iou1) : iou0;
  endtask

  task automatic job(input bit sel, input string tag, input logic [43:0] k, input logic [43:0] h,
                     input bit md, input longint unsigned exp_res, input int exp_lat);
    int lat;
    logic [21:0] res;
    start_job(sel, k, h, md);
    wait_done(sel, lat, res);
    check({tag, "_iou"}, 64'(res), 64'(exp_res));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_ovdrop"}, 64'(sel ? ov1 : ov0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [21:0] res;
    bit seen;
    longint unsigned rres;
    int rlat;
    logic [43:0] rk, rh;
    bit rmd;

    rst0 = 1'b1; iv0 = 1'b0; md0 = 1'b0; or0 = 1'b1; bk0 = '0; bh0 = '0;
    rst1 = 1'b1; iv1 = 1'b0; md1 = 1'b0; or1 = 1'b1; bk1 = '0; bh1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ir0), 64'd0);
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_iou", 64'(iou0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    check("post_rst_ready", 64'(ir0), 64'd1);

    // Partial overlap through the divider, both modes
    job(0, "t1_iou", box11(0, 0, 10, 10), box11(5, 5, 15, 15), 1, 599186, 25);
    job(0, "t1_dist", box11(0, 0, 10, 10), box11(5, 5, 15, 15), 0, 3595117, 25);
    job(0, "t2_half", box11(0, 0, 10, 10), box11(0, 0, 10, 20), 1, 2097152, 25);

    // Degenerate pairs bypass the divider
    job(0, "t2_ident_iou", box11(3, 4, 50, 60), box11(3, 4, 50, 60), 1, 4194303, 3);
    job(0, "t2_ident_dist", box11(3, 4, 50, 60), box11(3, 4, 50, 60), 0, 0, 3);
    job(0, "t3_disjoint", box11(0, 0, 10, 10), box11(20, 20, 30, 30), 0, 4194303, 3);
    job(0, "t3_touch", box11(0, 0, 10, 10), box11(10, 0, 20, 10), 0, 4194303, 3);
    job(0, "t3_zero_area", box11(5, 5, 5, 5), box11(9, 9, 2, 2), 0, 4194303, 3);
    job(0, "t3_max_coord", box11(0, 0, 2047, 2047), box11(0, 0, 2047, 2047), 1, 4194303, 3);

    // Backpressure in DONE with a competing request pending
    or0 = 1'b0;
    start_job(0, box11(3, 4, 50, 60), box11(3, 4, 50, 60), 1);
    wait_done(0, lat, res);
    check("bp_first_iou", 64'(res), 64'd4194303);
    bk0 = box11(0, 0, 10, 10); bh0 = box11(5, 5, 15, 15); md0 = 1'b0; iv0 = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(ov0), 64'd1);
      check("bp_hold_iou", 64'(iou0), 64'd4194303);
      check("bp_hold_ready", 64'(ir0), 64'd0);
    end
    md0 = 1'b1;
    or0 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(ov0), 64'd0);
    check("bp_release_ready", 64'(ir0), 64'd1);
    @(posedge clk); #1;
    iv0 = 1'b0;
    check("bp_pending_busy", 64'(busy0), 64'd1);
    wait_done(0, lat, res);
    check("bp_pending_iou", 64'(res), 64'd599186);
    check("bp_pending_lat", 64'(lat), 64'd25);
    @(posedge clk); #1;

    // Reset in the middle of the divide discards the job
    start_job(0, box11(0, 0, 10, 10), box11(5, 5, 15, 15), 1);
    repeat (10) @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    #1;
    check("midrst_valid", 64'(ov0), 64'd0);
    check("midrst_iou", 64'(iou0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_ready", 64'(ir0), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | ov0;
    end
    check("midrst_no_output", 64'(seen), 64'd0);
    job(0, "post_rst_job", box11(0, 0, 10, 10), box11(0, 0, 10, 20), 1, 2097152, 25);

    // Random pairs at COORD_W=8, FRAC_W=8, including inverted boxes
    for (int n = 0; n < 60; n++) begin
      int x0, y0, x1, y1, a0, b0, a1, b1;
      x0 = $urandom_range(0, 200); y0 = $urandom_range(0, 200);
      x1 = x0 + $urandom_range(0, 55); y1 = y0 + $urandom_range(0, 55);
      if ($urandom_range(0, 3) == 0) begin int t = x0; x0 = x1; x1 = t; end
      if ($urandom_range(0, 1) == 0) begin
        a0 = x0 + $urandom_range(0, 20) - 10; b0 = y0 + $urandom_range(0, 20) - 10;
        a1 = x1 + $urandom_range(0, 20) - 10; b1 = y1 + $urandom_range(0, 20) - 10;
        if (a0 < 0) a0 = 0;
        if (b0 < 0) b0 = 0;
        if (a1 > 255) a1 = 255;
        if (b1 > 255) b1 = 255;
      end else begin
        a0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255);
        a1 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
      end
      if (n == 5) begin a0 = x0; b0 = y0; a1 = x1; b1 = y1; end
      rk = box8(x0, y0, x1, y1);
      rh = box8(a0, b0, a1, b1);
      rmd = 1'($urandom_range(0, 1));
      ref_model(rk, rh, 8, 8, rmd, rres, rlat);
      job(1, "rand8", rk, rh, rmd, rres, rlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oflow_calc_iou_gen.md
Name: oflow_calc_iou_gen

Overview:
Parametrised, handshaked IoU engine for the oflow tracking path. It compares one bounding box from frame k with one box from the history frame and returns either IoU or IoU distance (1 - IoU) as an unsigned FRAC_W-bit fraction.
- Areas are derived internally from the box coordinates; no width or height inputs.
- Division is a bit-serial restoring divider.
- Degenerate cases short-circuit the divider.
- Sits between feature extraction and the cost/matching stage.

Parameters:
COORD_W, 11, width of one coordinate (X_TL/Y_TL/X_BR/Y_BR), unsigned
FRAC_W, 22, fraction bits of the result; 1.0 is represented as 2^FRAC_W-1

Ports:
clk  in  1  clock
reset_N  in  1  synchronous, active-high reset (asserted = 1), sampled on posedge clk
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request
mode  in  1  0 = output distance (1 - IoU), 1 = output raw IoU; latched on accept
bbox_k  in  4*COORD_W  frame-k box, packed {X_TL, Y_TL, X_BR, Y_BR}, X_TL in the MSBs
bbox_hist  in  4*COORD_W  history box, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
iou  out  FRAC_W  result per latched mode
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_N=1 at posedge): state=IDLE, in_ready=0 during the reset cycle, out_valid=0, iou=0, busy=0, all datapath registers=0. Reset mid-operation discards the job with no output.
- Accept: occurs on a posedge with in_valid && in_ready. in_ready = (state==IDLE) && !reset_N. bbox_k, bbox_hist and mode are registered at that edge; inputs are ignored afterwards.
- States: IDLE -> COORD -> AREA -> DIV -> DONE -> IDLE.
- COORD (1 cycle):
  - ix0 = max(X_TL); iy0 = max(Y_TL); ix1 = min(X_BR); iy1 = min(Y_BR). All compares unsigned.
  - Per box, w = (X_BR > X_TL) ? X_BR - X_TL : 0, and h likewise. An inverted box is treated as zero area.
- AREA (1 cycle):
  - Ak = wk*hk and Ah = wh*hh, each 2*COORD_W bits.
  - I = (ix1 > ix0 && iy1 > iy0) ? (ix1-ix0)*(iy1-iy0) : 0.
  - U = Ak + Ah - I, 2*COORD_W+1 bits, no overflow possible.
- Short-circuits taken from AREA directly to DONE:
  - U == 0: q = 0.
  - I == 0: q = 0.
  - I == U: q = 2^FRAC_W - 1 (saturated 1.0).
- DIV (exactly FRAC_W cycles):
  - Restoring divide computes q = floor(I * 2^FRAC_W / U), one quotient bit per cycle, MSB first.
  - Remainder register is 2*COORD_W+2 bits.
  - If q would reach 2^FRAC_W, it saturates to 2^FRAC_W-1; this is unreachable when I < U.
- DONE:
  - out_valid=1.
  - iou = mode ? q : (2^FRAC_W-1) - q.
  - iou and out_valid stay stable until out_ready is high at a posedge, then go to IDLE; out_valid drops the next cycle.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - FRAC_W+3 cycles through the divider (25 at default).
  - 3 cycles on a short-circuit.
- Throughput: one job in flight. The minimum request-to-request interval is latency + 1 cycle when out_ready is held high.
- Simultaneous events:
  - out_ready high in DONE on the same edge as in_valid: the new job is not accepted, because in_ready=0 in DONE. It is accepted on the following IDLE edge.
  - in_valid while busy is ignored; no queuing.
- iou holds its last value outside DONE; it is reset to 0 only by reset.

Test Plan:
1. Default params, mode=1. k=(0,0,10,10), hist=(5,5,15,15): I=25, U=175 -> iou=599186, out_valid exactly 25 cycles after accept. Repeat with mode=0 -> iou=3595117.
2. mode=1. k=(0,0,10,10), hist=(0,0,10,20): I=100, U=200 -> iou=2097152. Identical boxes (3,4,50,60) -> iou=4194303 after 3 cycles. Same with mode=0 -> iou=0.
3. Disjoint boxes k=(0,0,10,10), hist=(20,20,30,30), mode=0 -> iou=4194303 after 3 cycles. Touching edges k=(0,0,10,10), hist=(10,0,20,10) -> I=0, same result. Both boxes zero-area -> iou=4194303.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> iou and out_valid stable, in_ready=0, a second in_valid ignored. Raise out_ready -> one-cycle completion, then the pending request is accepted in IDLE.
5. Assert reset_N=1 for one cycle at DIV cycle 10 -> out_valid never rises for that job, iou=0, in_ready=1 the cycle after reset. A new job completes correctly.
6. Parameter sweep COORD_W=8, FRAC_W=8 with random boxes (including inverted boxes) vs a reference model -> bit-exact iou and latency FRAC_W+3 or 3.
